// File: rtl/hk_dna_reader.sv
// DNA_PORT sequencer: pulses READ for one dna_clk period, then shifts DNA_W bits
// out of the primitive and publishes them atomically with a sticky done flag.
module hk_dna_reader #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DNA_W   = 57
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DNA_W-1:0] dna_value_o,
  output logic [7:0]       rd_cnt_o,
  output logic             dna_clk_o,
  output logic             dna_read_o,
  output logic             dna_shift_o,
  output logic             dna_din_o,
  input  logic             dna_dout_i
);

  localparam int unsigned PH_W = $clog2(2 * CLK_DIV);
  localparam int unsigned BC_W = $clog2(DNA_W);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(DNA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t          state;
  logic            auto_start;
  logic [PH_W-1:0] phase;
  logic [BC_W-1:0] bit_cnt;
  logic [DNA_W-1:0] sr;
  logic [DNA_W-1:0] sr_next;
  logic            clk_next;

  assign sr_next   = {sr[DNA_W-2:0], dna_dout_i};
  // dna_clk level for phase+1; only used where phase is not about to wrap
  assign clk_next  = (32'(phase) + 32'd1) >= CLK_DIV;
  assign dna_din_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      auto_start  <= 1'b1;
      phase       <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      dna_value_o <= '0;
      rd_cnt_o    <= '0;
      dna_clk_o   <= 1'b0;
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i || auto_start) begin
            state      <= LOAD;
            phase      <= '0;
            auto_start <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= 1'b1;
            dna_read_o <= 1'b1;
            dna_clk_o  <= 1'b0;
          end
        end
        LOAD: begin
          if (phase == PH_LAST) begin
            state       <= SHIFT;
            phase       <= '0;
            bit_cnt     <= '0;
            dna_read_o  <= 1'b0;
            dna_shift_o <= 1'b1;
            dna_clk_o   <= 1'b0;
          end else begin
            phase     <= phase + 1'b1;
            dna_clk_o <= clk_next;
          end
        end
        SHIFT: begin
          if (phase == PH_SAMPLE) begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt + 1'b1;
          end
          // Final sample: publish and stop before issuing another rising edge
          if (phase == PH_SAMPLE && bit_cnt == BC_LAST) begin
            state       <= IDLE;
            phase       <= '0;
            dna_value_o <= sr_next;
            done_o      <= 1'b1;
            rd_cnt_o    <= rd_cnt_o + 8'd1;
            busy_o      <= 1'b0;
            dna_shift_o <= 1'b0;
            dna_clk_o   <= 1'b0;
          end else if (phase == PH_LAST) begin
            phase     <= '0;
            dna_clk_o <= 1'b0;
          end else begin
            phase     <= phase + 1'b1;
            dna_clk_o <= clk_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hk_dna_reader.sv
// Bench for hk_dna_reader: two instances (CLK_DIV=4 and 1), each with a DNA_PORT
// model, a cycle-count reference model and a READ/SHIFT protocol monitor.
module tb_hk_dna_reader;
  localparam int unsigned W = 57;

  logic        clk;
  logic [1:0]  rst, start, busy, done, dclk, dread, dshift, din, dout;
  logic [W-1:0] val [2];
  logic [7:0]   cnt [2];
  logic [W-1:0] dna [2];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned CD = (g == 0) ? 4 : 1;
    localparam int L = CD * (2 * W + 1);

    hk_dna_reader #(.CLK_DIV(CD), .DNA_W(W)) dut (
      .clk_i(clk), .rst_i(rst[g]), .start_i(start[g]),
      .busy_o(busy[g]), .done_o(done[g]), .dna_value_o(val[g]), .rd_cnt_o(cnt[g]),
      .dna_clk_o(dclk[g]), .dna_read_o(dread[g]), .dna_shift_o(dshift[g]),
      .dna_din_o(din[g]), .dna_dout_i(dout[g])
    );

    // DNA_PORT behaviour: READ loads the ID, SHIFT moves it up, DOUT is the MSB
    logic [W-1:0] preg;
    always @(posedge dclk[g]) begin
      if (dread[g]) preg <= dna[g];
      else if (dshift[g]) preg <= {preg[W-2:0], din[g]};
    end
    assign dout[g] = preg[W-1];

    bit m_busy, m_done, m_auto, m_fin;
    logic [W-1:0] m_val, m_dna;
    logic [7:0] m_cnt;
    int m_left, s, re_cnt, se_cnt;
    logic p_rd = 1'b0, p_sh = 1'b0, p_clk = 1'b0;

    always @(posedge clk) begin
      m_fin = 1'b0;
      if (rst[g]) begin
        m_busy = 0; m_done = 0; m_auto = 1; m_left = 0;
        m_val = '0; m_cnt = '0; re_cnt = 0; se_cnt = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_fin = 1;
          m_val = m_dna; m_cnt = m_cnt + 8'd1;
        end
      end else if (start[g] || m_auto) begin
        m_busy = 1; m_done = 0; m_auto = 0; m_left = L;
        m_dna = dna[g]; re_cnt = 0; se_cnt = 0;
      end
      #1;
      s = L - m_left + 1;
      chk($sformatf("busy%0d", g), busy[g], m_busy);
      chk($sformatf("done%0d", g), done[g], m_done);
      chk($sformatf("value%0d", g), val[g], m_val);
      chk($sformatf("rdcnt%0d", g), cnt[g], m_cnt);
      chk($sformatf("din%0d", g), din[g], 1'b0);
      if (m_busy) begin
        chk($sformatf("read%0d", g), dread[g], s <= 2 * CD);
        chk($sformatf("shift%0d", g), dshift[g], s > 2 * CD);
        chk($sformatf("dnaclk%0d", g), dclk[g], ((s - 1) % (2 * CD)) >= CD);
      end else begin
        chk($sformatf("idle_read%0d", g), dread[g], 1'b0);
        chk($sformatf("idle_shift%0d", g), dshift[g], 1'b0);
        chk($sformatf("idle_dnaclk%0d", g), dclk[g], 1'b0);
      end
      if (!rst[g]) begin
        if (dclk[g] && !p_clk) begin
          if (dread[g]) re_cnt++;
          if (dshift[g]) se_cnt++;
        end
        if (dread[g] != p_rd || dshift[g] != p_sh)
          chk($sformatf("rdsh_toggle_clkhigh%0d", g), dclk[g], 1'b0);
        if (m_fin) begin
          chk($sformatf("read_edges%0d", g), re_cnt, 1);
          chk($sformatf("shift_edges%0d", g), se_cnt, W - 1);
        end
      end
      p_rd = dread[g]; p_sh = dshift[g]; p_clk = dclk[g];
    end
  end

  task automatic wait_done(input int i, input int lim, output int t);
    int k = 0;
    while (done[i] !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (done[i] !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_done%0d got=timeout exp=done within %0d cycles", i, lim);
    end
    t = cyc;
  endtask

  function automatic logic [W-1:0] rnd_dna();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    int t0, t1, ncomp;
    logic prevd;
    rst = 2'b11; start = 2'b00;
    dna[0] = 57'h0823456789ABCDE;
    dna[1] = 57'h0AAAAAAAAAAAAAA;
    repeat (5) @(negedge clk);

    // auto-read after reset release
    rst[0] = 1'b0; t0 = cyc;
    wait_done(0, 600, t1);
    chk("auto_latency", t1 - t0, 461);
    chk("auto_value", val[0], 57'h0823456789ABCDE);
    chk("auto_rdcnt", cnt[0], 8'd1);

    // software start with new DNA; old value held during the read
    repeat (10) @(negedge clk);
    dna[0] = 57'h1FFFFFFFFFFFFFF;
    start[0] = 1'b1; t0 = cyc;
    @(negedge clk); start[0] = 1'b0;
    chk("start_done_low", done[0], 1'b0);
    chk("start_busy_high", busy[0], 1'b1);
    repeat (200) @(negedge clk);
    chk("value_held", val[0], 57'h0823456789ABCDE);
    wait_done(0, 600, t1);
    chk("sw_latency", t1 - t0, 461);
    chk("sw_value", val[0], 57'h1FFFFFFFFFFFFFF);
    chk("sw_rdcnt", cnt[0], 8'd2);

    // starts while busy and in the completion cycle are dropped
    start[0] = 1'b1; t0 = cyc;
    ncomp = 0; prevd = 1'b1; t1 = -1;
    for (int c = 1; c <= 470; c++) begin
      @(negedge clk);
      start[0] = ((c % 50 == 0) && c < 460) || c == 460;
      if (done[0] && !prevd) begin
        ncomp++;
        if (t1 < 0) t1 = cyc;
      end
      prevd = done[0];
    end
    chk("busy_starts_ncomp", ncomp, 1);
    chk("busy_starts_latency", t1 - t0, 461);
    chk("busy_starts_rdcnt", cnt[0], 8'd3);
    chk("busy_starts_idle", busy[0], 1'b0);

    // start in the first idle cycle after completion is accepted
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_done(0, 600, t1);
    start[0] = 1'b1; t0 = cyc;
    @(negedge clk); start[0] = 1'b0;
    chk("first_idle_busy", busy[0], 1'b1);
    wait_done(0, 600, t1);
    chk("first_idle_latency", t1 - t0, 461);
    chk("first_idle_rdcnt", cnt[0], 8'd5);

    // reset in the middle of a read
    dna[0] = 57'h0123456789ABCDE;
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (199) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_value", val[0], 57'h0);
    chk("midrst_rdcnt", cnt[0], 8'd0);
    chk("midrst_dnaclk", dclk[0], 1'b0);
    rst[0] = 1'b0; t0 = cyc;
    wait_done(0, 600, t1);
    chk("midrst_latency", t1 - t0, 461);
    chk("midrst_reread", val[0], 57'h0123456789ABCDE);

    // random DNA, random gaps, random start noise during reads
    for (int r = 0; r < 15; r++) begin
      repeat ($urandom_range(20)) @(negedge clk);
      dna[0] = rnd_dna();
      start[0] = 1'b1;
      for (int k = 0; k < 600; k++) begin
        @(negedge clk);
        if (done[0]) begin
          start[0] = 1'b0;
          break;
        end
        start[0] = ($urandom_range(7) == 0);
      end
    end
    start[0] = 1'b0;

    // CLK_DIV=1 instance: auto-read then 255 back-to-back reads to wrap rd_cnt
    rst[1] = 1'b0; t0 = cyc;
    wait_done(1, 200, t1);
    chk("div1_latency", t1 - t0, 116);
    chk("div1_value", val[1], 57'h0AAAAAAAAAAAAAA);
    for (int i = 1; i < 256; i++) begin
      dna[1] = rnd_dna();
      start[1] = 1'b1; t0 = cyc;
      @(negedge clk); start[1] = 1'b0;
      wait_done(1, 200, t1);
      chk("div1_rd_latency", t1 - t0, 116);
    end
    chk("div1_rdcnt_wrap", cnt[1], 8'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
